// File: rtl/fnd_scan_controller.sv
// Multiplexed N-digit 7-segment scan driver with frame-synchronous shadow loading,
// per-slot dead time, leading-zero blanking and per-digit decimal point. Optional: FND_BLINK_EN.
module fnd_scan_controller #(
    parameter int CLK_HZ       = 100_000_000,
    parameter int SCAN_HZ      = 1_000,
    parameter int DIGITS       = 4,
    parameter int BLANK_CYCLES = 1_000
`ifdef FND_BLINK_EN
    ,
    parameter int BLINK_HZ     = 2
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   i_digits,
    input  logic [DIGITS-1:0]     i_dp,
    input  logic                  i_load,
    input  logic                  i_lzb,
`ifdef FND_BLINK_EN
    input  logic [DIGITS-1:0]     i_blink,
`endif
    output logic                  o_frame,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     seg_comm
);

    localparam int DIV   = CLK_HZ / SCAN_HZ;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W = $clog2(DIGITS);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

    typedef enum logic {BLANK, SHOW} state_t;
    localparam state_t RESET_STATE = (BLANK_CYCLES == 0) ? SHOW : BLANK;

    state_t              state, state_next;
    logic [CNT_W-1:0]    slot_cnt;
    logic [IDX_W-1:0]    idx;
    logic [4*DIGITS-1:0] disp_digits, pend_digits;
    logic [DIGITS-1:0]   disp_dp, pend_dp;
    logic                pend_valid;
    logic                slot_end, frame_end;
    logic [DIGITS-1:0]   lz_mask, dark_mask;
    logic [3:0]          cur_nib;
    logic [7:0]          seg_next;
    logic [DIGITS-1:0]   comm_next;

    function automatic logic [7:0] decode(input logic [3:0] n);
        case (n)
            4'h0: decode = 8'hC0;  4'h1: decode = 8'hF9;
            4'h2: decode = 8'hA4;  4'h3: decode = 8'hB0;
            4'h4: decode = 8'h99;  4'h5: decode = 8'h92;
            4'h6: decode = 8'h82;  4'h7: decode = 8'hF8;
            4'h8: decode = 8'h80;  4'h9: decode = 8'h90;
            4'hA: decode = 8'h88;  4'hB: decode = 8'h83;
            4'hC: decode = 8'hC6;  4'hD: decode = 8'hA1;
            4'hE: decode = 8'h86;  default: decode = 8'h8E;
        endcase
    endfunction

    assign slot_end  = (slot_cnt == SLOT_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_cnt <= '0;
            idx      <= '0;
        end else if (slot_end) begin
            slot_cnt <= '0;
            idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= RESET_STATE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            BLANK:   if (BLANK_CYCLES == 0 || slot_cnt == BLANK_LAST) state_next = SHOW;
            SHOW:    if (slot_end && BLANK_CYCLES != 0) state_next = BLANK;
            default: state_next = RESET_STATE;
        endcase
    end

    // A load landing on the boundary cycle goes straight to the display registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp_digits <= '0;
            disp_dp     <= '0;
            pend_digits <= '0;
            pend_dp     <= '0;
            pend_valid  <= 1'b0;
            o_frame     <= 1'b0;
        end else begin
            o_frame <= frame_end && (i_load || pend_valid);
            if (frame_end && i_load) begin
                disp_digits <= i_digits;
                disp_dp     <= i_dp;
                pend_valid  <= 1'b0;
            end else if (frame_end && pend_valid) begin
                disp_digits <= pend_digits;
                disp_dp     <= pend_dp;
                pend_valid  <= 1'b0;
            end else if (i_load) begin
                pend_digits <= i_digits;
                pend_dp     <= i_dp;
                pend_valid  <= 1'b1;
            end
        end
    end

    // Walk down from the top digit; a digit stays dark while everything above it is blank zero.
    always_comb begin : lzb_scan
        logic run;
        lz_mask = '0;
        run     = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            run        = run && (disp_digits[4*k +: 4] == 4'h0) && !disp_dp[k];
            lz_mask[k] = i_lzb && run && (k != 0);
        end
    end

`ifdef FND_BLINK_EN
    localparam int BLINK_HALF = CLK_HZ / (2 * BLINK_HZ);
    localparam int BLINK_W    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_W'(BLINK_HALF - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign dark_mask = lz_mask | (blink_phase ? i_blink : '0);
`else
    assign dark_mask = lz_mask;
`endif

    assign cur_nib = disp_digits[4*idx +: 4];

    always_comb begin
        seg_next  = 8'hFF;
        comm_next = '1;
        if (state == SHOW && !dark_mask[idx]) begin
            seg_next = decode(cur_nib);
            if (disp_dp[idx]) seg_next[7] = 1'b0;
            comm_next = ~(DIGITS'(1) << idx);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg      <= 8'hFF;
            seg_comm <= '1;
        end else begin
            seg      <= seg_next;
            seg_comm <= comm_next;
        end
    end

endmodule
